// File: rtl/memarb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package memarb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam int unsigned MEM_LAT_MAX = 15;
    localparam int unsigned CNT_W       = $clog2(MEM_LAT_MAX + 1);

    localparam logic [63:0] WORD_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/memarb_byte_ext.sv
// Selects one little-endian byte of a word and sign-extends it to DW bits.
// Used by mem_port_arbiter only when MEMARB_LB_EXT_EN is defined.
module memarb_byte_ext #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] word,
    input  logic [1:0]    ofs,
    output logic [DW-1:0] ext
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte = word[7:0];
        case (ofs)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        ext = {{(DW-8){sel_byte[7]}}, sel_byte};
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and DM requests onto one single-ported memory with fixed read latency.
// Optional MEMARB_LB_EXT_EN: byte extraction with sign extension for DM lb loads.
module mem_port_arbiter
    import memarb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic          dm_lb,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t           state_q, state_d;
    owner_t           owner_q, grant_owner;
    logic             grant;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    if_rdata_q, dm_rdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic             capture;
    logic [DW-1:0]    load_word;
    logic [AW-1:0]    grant_addr;
    logic             grant_we;
    logic [DW-1:0]    grant_wdata;

    // RESP hands the port to the other requester directly, so IF cannot be starved by DM.
    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_owner = OWN_IF;
        case (state_q)
            IDLE: begin
                if (dm_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_DM;
                    state_d     = ISSUE;
                end else if (if_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_IF;
                    state_d     = ISSUE;
                end
            end
            ISSUE: state_d = we_q ? RESP : WAIT;
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q == OWN_IF && dm_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_DM;
                    state_d     = ISSUE;
                end else if (owner_q == OWN_DM && if_req) begin
                    grant       = 1'b1;
                    grant_owner = OWN_IF;
                    state_d     = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_addr  = if_addr;
        grant_we    = 1'b0;
        grant_wdata = '0;
        if (grant_owner == OWN_DM) begin
            grant_addr  = dm_addr;
            grant_we    = dm_we;
            grant_wdata = dm_wdata;
        end
    end

    assign capture = (state_q == WAIT) && (cnt_q == '0);

`ifdef MEMARB_LB_EXT_EN
    logic          lb_q;
    logic [1:0]    ofs_q;
    logic [DW-1:0] ext_word;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lb_q  <= 1'b0;
            ofs_q <= '0;
        end else if (grant) begin
            lb_q  <= (grant_owner == OWN_DM) && dm_lb && !dm_we;
            ofs_q <= grant_addr[1:0];
        end
    end

    memarb_byte_ext #(.DW(DW)) u_byte_ext (
        .word (mem_rdata),
        .ofs  (ofs_q),
        .ext  (ext_word)
    );

    assign load_word = (owner_q == OWN_DM && lb_q) ? ext_word : mem_rdata;
`else
    logic unused_lb;
    assign unused_lb = dm_lb;
    assign load_word = mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= grant_owner;
                we_q    <= grant_we;
                addr_q  <= grant_addr & WORD_ALIGN_MASK[AW-1:0];
                wdata_q <= grant_wdata;
            end
            if (state_q == ISSUE && !we_q) begin
                cnt_q <= CNT_W'(MEM_LAT - 1);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                if (owner_q == OWN_DM) begin
                    dm_rdata_q <= load_word;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
    assign dm_ack    = (state_q == RESP) && (owner_q == OWN_DM);
    assign if_stall  = if_req & ~if_ack;
    assign dm_stall  = dm_req & ~dm_ack;
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
// Expected lb results follow MEMARB_LB_EXT_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int NCYC = 3000;
`ifdef MEMARB_LB_EXT_EN
    localparam bit LBEXT = 1'b1;
`else
    localparam bit LBEXT = 1'b0;
`endif

    typedef struct {
        int          start;
        logic        we;
        logic        lb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        if_req, if_ack, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_lb, dm_ack, dm_stall;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_lb(dm_lb), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] mac_mem [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] lb_value(input logic [31:0] w, input logic [1:0] ofs);
        logic [7:0] b;
        b = 8'(w >> (8 * ofs));
        return {{24{b[7]}}, b};
    endfunction

    initial begin
        req_t        if_dir[$];
        req_t        dm_dir[$];
        req_t        r;
        bit          busy, own_dm, cur_we, post_rst;
        int          issue_c, ack_c, rd_due;
        logic [31:0] cur_addr, cur_wdata, cur_data, rd_word, exp_if, exp_dm;
        logic        e_if_ack, e_dm_ack, e_en, e_we, take_if, take_dm;
        logic        nx_rst_n, nx_if_req, nx_dm_req, nx_dm_we, nx_dm_lb;
        logic [31:0] nx_if_addr, nx_dm_addr, nx_dm_wdata, nx_mrd;

        busy = 0; own_dm = 0; cur_we = 0; post_rst = 0;
        issue_c = -1; ack_c = -1; rd_due = -1;
        cur_addr = '0; cur_wdata = '0; cur_data = '0; rd_word = '0; exp_if = '0; exp_dm = '0;

        for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
        ref_mem[widx(32'h40)]  = 32'h2008_0005;
        ref_mem[widx(32'h102)] = 32'h1280_3456;
        for (int i = 0; i < 256; i++) mac_mem[i] = ref_mem[i];

        if_dir.push_back('{4,  1'b0, 1'b0, 32'h0000_0040, 32'h0});
        dm_dir.push_back('{10, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF});
        dm_dir.push_back('{14, 1'b0, 1'b1, 32'h0000_0102, 32'h0});
        dm_dir.push_back('{20, 1'b0, 1'b0, 32'h0000_0083, 32'h0});
        if_dir.push_back('{20, 1'b0, 1'b0, 32'h0000_0040, 32'h0});
        if_dir.push_back('{30, 1'b0, 1'b0, 32'h0000_0048, 32'h0});

        reset_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_lb = 1'b0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = $urandom;

        while (cyc < NCYC) begin
            @(negedge clk);
            if (busy && ack_c == cyc && !cur_we) begin
                if (own_dm) exp_dm = cur_data;
                else        exp_if = cur_data;
            end
            e_if_ack = busy && ack_c == cyc && !own_dm;
            e_dm_ack = busy && ack_c == cyc && own_dm;
            e_en     = busy && issue_c == cyc;
            e_we     = e_en && cur_we;

            if (cyc > 0) begin
                check("if_ack",   64'(if_ack),   64'(e_if_ack));
                check("dm_ack",   64'(dm_ack),   64'(e_dm_ack));
                check("mem_en",   64'(mem_en),   64'(e_en));
                check("mem_we",   64'(mem_we),   64'(e_we));
                check("if_rdata", 64'(if_rdata), 64'(exp_if));
                check("dm_rdata", 64'(dm_rdata), 64'(exp_dm));
                check("if_stall", 64'(if_stall), 64'(if_req & ~e_if_ack));
                check("dm_stall", 64'(dm_stall), 64'(dm_req & ~e_dm_ack));
                if (e_en) begin
                    check("mem_addr", 64'(mem_addr), 64'({cur_addr[31:2], 2'b00}));
                    if (cur_we) check("mem_wdata", 64'(mem_wdata), 64'(cur_wdata));
                end
                if (post_rst) begin
                    check("rst_mem_addr",  64'(mem_addr),  64'(0));
                    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
                end
            end

            // memory macro behaviour, driven by what the DUT actually issues
            if (mem_en === 1'b1) begin
                if (mem_we) begin
                    mac_mem[widx(mem_addr)] = mem_wdata;
                end else begin
                    rd_due  = cyc + LAT;
                    rd_word = mac_mem[widx(mem_addr)];
                end
            end

            // reference model: one access at a time, decided when the port is free or handing off
            if (!reset_n) begin
                busy = 0; exp_if = '0; exp_dm = '0; post_rst = 1;
            end else begin
                post_rst = 0;
                if (!busy || ack_c == cyc) begin
                    take_dm = dm_req && !e_dm_ack;
                    take_if = if_req && !e_if_ack;
                    if (take_dm || take_if) begin
                        busy      = 1;
                        own_dm    = take_dm;
                        cur_addr  = take_dm ? dm_addr : if_addr;
                        cur_we    = take_dm && dm_we;
                        cur_wdata = dm_wdata;
                        issue_c   = cyc + 1;
                        ack_c     = cyc + 2 + (cur_we ? 0 : LAT);
                        if (cur_we) begin
                            ref_mem[widx(cur_addr)] = cur_wdata;
                        end else if (LBEXT && take_dm && dm_lb) begin
                            cur_data = lb_value(ref_mem[widx(cur_addr)], cur_addr[1:0]);
                        end else begin
                            cur_data = ref_mem[widx(cur_addr)];
                        end
                    end else begin
                        busy = 0;
                    end
                end
            end

            nx_if_req = if_req; nx_if_addr = if_addr;
            if (!if_req || if_ack) begin
                nx_if_req = 1'b0;
                if (if_dir.size() > 0) begin
                    if (if_dir[0].start <= cyc + 1) begin
                        r = if_dir.pop_front();
                        nx_if_req = 1'b1; nx_if_addr = r.addr;
                    end
                end else if (cyc >= 40 && $urandom_range(0, 2) == 0) begin
                    nx_if_req = 1'b1; nx_if_addr = $urandom;
                end
            end
            nx_dm_req = dm_req; nx_dm_we = dm_we; nx_dm_lb = dm_lb;
            nx_dm_addr = dm_addr; nx_dm_wdata = dm_wdata;
            if (!dm_req || dm_ack) begin
                nx_dm_req = 1'b0;
                if (dm_dir.size() > 0) begin
                    if (dm_dir[0].start <= cyc + 1) begin
                        r = dm_dir.pop_front();
                        nx_dm_req = 1'b1; nx_dm_we = r.we; nx_dm_lb = r.lb;
                        nx_dm_addr = r.addr; nx_dm_wdata = r.wdata;
                    end
                end else if (cyc >= 40 && $urandom_range(0, 2) == 0) begin
                    nx_dm_req = 1'b1; nx_dm_we = ($urandom_range(0, 2) == 0);
                    nx_dm_lb = 1'($urandom_range(0, 1));
                    nx_dm_addr = $urandom; nx_dm_wdata = $urandom;
                end
            end
            nx_rst_n = !((cyc + 1 < 3) || (cyc + 1 == 32) ||
                         (cyc >= 40 && busy && $urandom_range(0, 59) == 0));
            nx_mrd = (cyc + 1 == rd_due) ? rd_word : $urandom;

            @(posedge clk);
            #1;
            reset_n = nx_rst_n;
            if_req = nx_if_req; if_addr = nx_if_addr;
            dm_req = nx_dm_req; dm_we = nx_dm_we; dm_lb = nx_dm_lb;
            dm_addr = nx_dm_addr; dm_wdata = nx_dm_wdata;
            mem_rdata = nx_mrd;
            cyc++;
        end

        check("sweep_lat1_done",  64'(g_sweep[0].done), 64'(1));
        check("sweep_lat15_done", 64'(g_sweep[1].done), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Extra instances at the latency extremes: one IF load each, timed from the request cycle.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int          L    = (g == 0) ? 1 : 15;
        localparam logic [31:0] WORD = 32'hA5C3_0000 + 32'(L);

        logic        s_rstn, s_req, s_ack, s_stall, s_dack, s_dstall, s_en, s_we;
        logic [31:0] s_rdata, s_drdata, s_maddr, s_mwdata, s_mrd;
        bit          done = 1'b0;

        mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) u_sweep (
            .clk(clk), .reset_n(s_rstn),
            .if_req(s_req), .if_addr(32'h0000_0044), .if_ack(s_ack), .if_rdata(s_rdata), .if_stall(s_stall),
            .dm_req(1'b0), .dm_we(1'b0), .dm_lb(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
            .dm_ack(s_dack), .dm_rdata(s_drdata), .dm_stall(s_dstall),
            .mem_en(s_en), .mem_we(s_we), .mem_addr(s_maddr), .mem_wdata(s_mwdata),
            .mem_rdata(s_mrd)
        );

        initial begin
            int          c, issue, ackc;
            logic [31:0] got;
            s_rstn = 1'b0; s_req = 1'b0; s_mrd = $urandom;
            got = '0;
            repeat (3) @(posedge clk);
            #1 s_rstn = 1'b1;
            @(posedge clk);
            #1 s_req = 1'b1;
            c = 0; issue = -1; ackc = -1;
            while (c < 40 && ackc < 0) begin
                @(negedge clk);
                if (c == 0) check($sformatf("lat%0d_stall", L), 64'(s_stall), 64'(1));
                if (s_en === 1'b1 && issue < 0) issue = c;
                if (s_ack === 1'b1) begin
                    ackc = c;
                    got  = s_rdata;
                    check($sformatf("lat%0d_dm_ack", L), 64'(s_dack), 64'(0));
                end
                @(posedge clk);
                #1;
                c++;
                s_mrd = (issue >= 0 && c == issue + L) ? WORD : $urandom;
                if (ackc >= 0) s_req = 1'b0;
            end
            check($sformatf("lat%0d_issue", L), 64'(issue), 64'(1));
            check($sformatf("lat%0d_ack_cycle", L), 64'(ackc), 64'(2 + L));
            check($sformatf("lat%0d_rdata", L), 64'(got), 64'(WORD));
            done = 1'b1;
        end
    end

endmodule
